// File: rtl/multi_step_seqr.sv
// Step sequencer: starts NUM_STEPS engines one at a time, with per-run bypass, abort and
// an optional per-step watchdog enabled by defining MULTI_STEP_SEQR_TIMEOUT_EN.
module multi_step_seqr #(
    parameter int unsigned NUM_STEPS      = 4,
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    parameter int unsigned STEP_W         = $clog2(NUM_STEPS)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 run,
    input  logic [NUM_STEPS-1:0] step_en,
    input  logic                 abort,
    input  logic                 clr,
    output logic [NUM_STEPS-1:0] step_run,
    input  logic [NUM_STEPS-1:0] step_done,
    output logic [STEP_W-1:0]    cur_step,
    output logic                 busy,
    output logic                 done,
    output logic                 err,
    output logic [1:0]           err_code
);

    typedef enum logic [1:0] {StIdle, StStep, StDone, StErr} state_e;

    localparam logic [STEP_W-1:0] LastStep = STEP_W'(NUM_STEPS - 1);
    localparam logic [1:0] ErrNone    = 2'd0;
    localparam logic [1:0] ErrAbort   = 2'd1;
    localparam logic [1:0] ErrTimeout = 2'd2;

    state_e                state_q, state_d;
    logic [STEP_W-1:0]     cur_step_q, cur_step_d;
    logic [NUM_STEPS-1:0]  en_q, en_d;
    logic [1:0]            err_code_q, err_code_d;
    logic                  cur_en;
    logic                  cur_done;

    assign cur_en   = en_q[cur_step_q];
    assign cur_done = step_done[cur_step_q];

`ifdef MULTI_STEP_SEQR_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CntLast = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    // Watchdog not built; the parameter is kept only for a uniform interface.
    logic [31:0] timeout_unused;
    assign timeout_unused = 32'(TIMEOUT_CYCLES);
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            cur_step_q <= '0;
            en_q       <= '0;
            err_code_q <= ErrNone;
        end else begin
            state_q    <= state_d;
            cur_step_q <= cur_step_d;
            en_q       <= en_d;
            err_code_q <= err_code_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cur_step_d = cur_step_q;
        en_d       = en_q;
        err_code_d = err_code_q;
`ifdef MULTI_STEP_SEQR_TIMEOUT_EN
        cnt_d      = cnt_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (run) begin
                    state_d    = StStep;
                    cur_step_d = '0;
                    en_d       = step_en;
`ifdef MULTI_STEP_SEQR_TIMEOUT_EN
                    cnt_d      = '0;
`endif
                end
            end
            StStep: begin
                // Abort wins over done and timeout; a disabled step always advances.
                if (abort) begin
                    state_d    = StErr;
                    err_code_d = ErrAbort;
                end else if (!cur_en || cur_done) begin
                    if (cur_step_q == LastStep) begin
                        state_d = StDone;
                    end else begin
                        cur_step_d = cur_step_q + 1'b1;
`ifdef MULTI_STEP_SEQR_TIMEOUT_EN
                        cnt_d      = '0;
`endif
                    end
                end
`ifdef MULTI_STEP_SEQR_TIMEOUT_EN
                else if (cnt_q == CntLast) begin
                    state_d    = StErr;
                    err_code_d = ErrTimeout;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            StDone, StErr: begin
                if (clr) begin
                    state_d    = StIdle;
                    cur_step_d = '0;
                    err_code_d = ErrNone;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        step_run = '0;
        if (state_q == StStep && cur_en) begin
            step_run[cur_step_q] = 1'b1;
        end
    end

    assign cur_step = cur_step_q;
    assign busy     = (state_q == StStep);
    assign done     = (state_q == StDone);
    assign err      = (state_q == StErr);
    assign err_code = err_code_q;

endmodule

// File: tb/tb_multi_step_seqr.sv
// Bench for multi_step_seqr: vector table through a scoreboard queue, plus hand sequences
// for asynchronous reset and (when MULTI_STEP_SEQR_TIMEOUT_EN is defined) the watchdog.
module tb_multi_step_seqr;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       run = 1'b0;
    logic [3:0] step_en = '0;
    logic       abort = 1'b0;
    logic       clr = 1'b0;
    logic [3:0] step_run;
    logic [3:0] step_done = '0;
    logic [1:0] cur_step;
    logic       busy, done, err;
    logic [1:0] err_code;

    int total = 0;
    int passed = 0;

    multi_step_seqr #(
        .NUM_STEPS      (4),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .run       (run),
        .step_en   (step_en),
        .abort     (abort),
        .clr       (clr),
        .step_run  (step_run),
        .step_done (step_done),
        .cur_step  (cur_step),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .err_code  (err_code)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        run;
        logic [3:0]  en;
        logic        abort;
        logic        clr;
        logic [3:0]  sd;
        logic [10:0] exp;
    } vec_t;

    vec_t         tbl[$];
    logic [10:0]  sb[$];

    // Expected word: {step_run, cur_step, busy, done, err, err_code}; xs = {busy, done, err}.
    function automatic vec_t v(input int r, input int en, input int ab, input int cl,
                               input int sd, input int xr, input int xc, input int xs,
                               input int xe);
        vec_t t;
        t.run   = 1'(r);
        t.en    = 4'(en);
        t.abort = 1'(ab);
        t.clr   = 1'(cl);
        t.sd    = 4'(sd);
        t.exp   = {4'(xr), 2'(xc), 3'(xs), 2'(xe)};
        return t;
    endfunction

    function automatic logic [10:0] outs();
        return {step_run, cur_step, busy, done, err, err_code};
    endfunction

    task automatic check(input string name, input logic [10:0] act, input logic [10:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %b required %b", name, act, exp);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        run = 1'b0; step_en = '0; abort = 1'b0; clr = 1'b0; step_done = '0;
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: got running required finished");
        $fatal(1, "bench time limit");
    end

    initial begin
        int n;
        logic [10:0] exp;

        // All enabled, each done 3 cycles after its run rises.
        tbl.push_back(v(1, 'hF, 0, 0, 0,    1, 0, 4, 0));
        tbl.push_back(v(0, 0, 0, 0, 'hE,    1, 0, 4, 0));
        tbl.push_back(v(0, 0, 0, 1, 0,      1, 0, 4, 0));
        tbl.push_back(v(0, 0, 0, 0, 1,      2, 1, 4, 0));
        tbl.push_back(v(0, 0, 0, 0, 0,      2, 1, 4, 0));
        tbl.push_back(v(0, 0, 0, 0, 0,      2, 1, 4, 0));
        tbl.push_back(v(0, 0, 0, 0, 2,      4, 2, 4, 0));
        tbl.push_back(v(0, 0, 0, 0, 0,      4, 2, 4, 0));
        tbl.push_back(v(0, 0, 0, 0, 0,      4, 2, 4, 0));
        tbl.push_back(v(0, 0, 0, 0, 4,      8, 3, 4, 0));
        tbl.push_back(v(0, 0, 0, 0, 0,      8, 3, 4, 0));
        tbl.push_back(v(0, 0, 0, 0, 0,      8, 3, 4, 0));
        tbl.push_back(v(0, 0, 0, 0, 8,      0, 3, 2, 0));
        tbl.push_back(v(1, 'hF, 1, 0, 0,    0, 3, 2, 0));
        tbl.push_back(v(1, 0, 0, 1, 0,      0, 0, 0, 0));
        // Mask 1010, done immediately, done pulsed during a bypass.
        tbl.push_back(v(1, 'hA, 0, 0, 0,    0, 0, 4, 0));
        tbl.push_back(v(0, 0, 0, 0, 1,      2, 1, 4, 0));
        tbl.push_back(v(0, 0, 0, 0, 2,      0, 2, 4, 0));
        tbl.push_back(v(0, 0, 0, 0, 0,      8, 3, 4, 0));
        tbl.push_back(v(0, 0, 0, 0, 8,      0, 3, 2, 0));
        tbl.push_back(v(0, 0, 0, 1, 0,      0, 0, 0, 0));
        tbl.push_back(v(0, 0, 1, 0, 0,      0, 0, 0, 0));
        tbl.push_back(v(0, 0, 0, 1, 'hF,    0, 0, 0, 0));
        // Abort together with done of step 1.
        tbl.push_back(v(1, 'hF, 0, 0, 0,    1, 0, 4, 0));
        tbl.push_back(v(0, 0, 0, 0, 1,      2, 1, 4, 0));
        tbl.push_back(v(0, 0, 1, 0, 2,      0, 1, 1, 1));
        tbl.push_back(v(1, 0, 0, 0, 0,      0, 1, 1, 1));
        tbl.push_back(v(0, 0, 0, 1, 0,      0, 0, 0, 0));

        #1;
        check("reset_async", outs(), 11'd0);
        cyc();
        cyc();
        check("reset_hold", outs(), 11'd0);
        rst = 1'b0;

        for (int i = 0; i < tbl.size(); i++) begin
            run = tbl[i].run; step_en = tbl[i].en; abort = tbl[i].abort;
            clr = tbl[i].clr; step_done = tbl[i].sd;
            sb.push_back(tbl[i].exp);
            cyc();
            exp = sb.pop_front();
            check($sformatf("vec[%0d]", i), outs(), exp);
        end
        idle_inputs();

        // Asynchronous reset while step 1 runs, then a clean restart.
        run = 1'b1; step_en = 4'hF;
        cyc();
        run = 1'b0; step_done = 4'h1;
        cyc();
        step_done = '0;
        check("rst_pre_step1", outs(), {4'h2, 2'd1, 3'b100, 2'd0});
        #2 rst = 1'b1;
        #1;
        check("rst_mid_run", outs(), 11'd0);
        cyc();
        rst = 1'b0;
        run = 1'b1; step_en = 4'hF;
        cyc();
        run = 1'b0;
        check("restart_step0", outs(), {4'h1, 2'd0, 3'b100, 2'd0});
        for (int i = 0; i < 4; i++) begin
            step_done = 4'(1 << i);
            cyc();
        end
        step_done = '0;
        check("restart_done", outs(), {4'h0, 2'd3, 3'b010, 2'd0});
        clr = 1'b1;
        cyc();
        clr = 1'b0;

`ifdef MULTI_STEP_SEQR_TIMEOUT_EN
        // Step 2 never done: exactly 8 run cycles, then timeout.
        run = 1'b1; step_en = 4'b0100;
        cyc();
        run = 1'b0;
        n = 0;
        for (int k = 0; k < 20 && !err; k++) begin
            if (step_run[2]) n++;
            cyc();
        end
        check("timeout_state", outs(), {4'h0, 2'd2, 3'b001, 2'd2});
        check("timeout_run_cycles", 11'(n), 11'd8);
        clr = 1'b1;
        cyc();
        clr = 1'b0;
        // Done in the final allowed cycle wins over timeout.
        run = 1'b1; step_en = 4'b0100;
        cyc();
        run = 1'b0;
        cyc();
        for (int k = 0; k < 8; k++) cyc();
        check("timeout_last_cycle", outs(), {4'h4, 2'd2, 3'b100, 2'd0});
        step_done = 4'b0100;
        cyc();
        step_done = '0;
        check("timeout_done_wins", outs(), {4'h0, 2'd3, 3'b100, 2'd0});
        cyc();
        check("timeout_done_final", outs(), {4'h0, 2'd3, 3'b010, 2'd0});
        clr = 1'b1;
        cyc();
        clr = 1'b0;
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/multi_step_seqr.md
# multi_step_seqr

Parametrised step sequencer for the edge-detector datapath. It starts `NUM_STEPS` processing steps one at a time, in index order, and advances on each step's done strobe. Individual steps can be bypassed per run. A run can be aborted, and an optional per-step watchdog flags stalled steps. It sits between the top-level control registers and the per-step engines, such as intensity gradient, edge thinning, edge tracking, and rectify/clip.

## Interface
- `NUM_STEPS`, default 4: number of sequenced steps; legal range 2..16.
- `TIMEOUT_CYCLES`, default 1024: maximum run cycles per enabled step; legal range ≥2; used only with the watchdog.
- `STEP_W`, default `$clog2(NUM_STEPS)`: derived; step index width.
- `clk` in 1: clock, rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `run` in 1: start request; sampled only in IDLE.
- `step_en` in NUM_STEPS: per-step enable mask, captured when `run` is accepted.
- `abort` in 1: terminates an active sequence.
- `clr` in 1: returns from DONE/ERR to IDLE.
- `step_run` out NUM_STEPS: one-hot run level to the step engines, or all zero.
- `step_done` in NUM_STEPS: per-step done; only bit `cur_step` is observed, and only while that step is running.
- `cur_step` out STEP_W: index of the current step.
- `busy` out 1: high in STEP state.
- `done` out 1: high in DONE state.
- `err` out 1: high in ERR state.
- `err_code` out 2: 0 = none, 1 = abort, 2 = timeout; 3 is reserved; held in ERR.

## Operation
- States are IDLE, STEP, DONE and ERR. The registers are `state`, `cur_step`, `en_q` (captured mask), `err_code` and the watchdog counter `cnt`.
- IDLE with `run`=1:
  - Next state is STEP with `cur_step`=0.
  - `en_q` ← `step_en`.
  - `cnt` ← 0.
- STEP, step enabled (`en_q[cur_step]`=1):
  - `step_run[cur_step]`=1; all other bits are 0.
  - When `step_done[cur_step]`=1, advance.
- STEP, step disabled (bypassed):
  - `step_run` is all zero.
  - Advance unconditionally after exactly one cycle.
- Advance:
  - If `cur_step`==NUM_STEPS-1, go to DONE.
  - Otherwise `cur_step`+1, and `cnt` ← 0.
- A disabled step with an asserted done strobe is treated as a bypass.
- Done bits of non-current steps are ignored in all states.
- `abort` in STEP:
  - Go to ERR, `err_code`=1.
  - Abort has priority over done and timeout in the same cycle.
  - `abort` in IDLE, DONE or ERR is ignored.
- DONE and ERR are sticky:
  - `run` is ignored.
  - `clr`=1 gives IDLE next cycle, and `err_code` ← 0.
  - `clr` in IDLE or STEP is ignored.
- `cur_step` holds its last value in DONE and ERR, which identifies the failing step. It returns to 0 on entering IDLE.
- Reset values:
  - `state`=IDLE, `cur_step`=0, `en_q`=0, `cnt`=0, `err_code`=0.
  - Hence `step_run`=0, `busy`=0, `done`=0, `err`=0.
- A reset asserted mid-run returns to IDLE immediately and asynchronously. `step_run` drops in the same instant.

## Timing
- All outputs decode directly from registered state, so there is no combinational path from input to output.
- If `run` is accepted at edge N, `step_run[0]` is high from edge N to edge N+1 onward.
- If `step_done[k]` is sampled high at edge M:
  - `step_run[k]` is low after M.
  - `step_run[k+1]` is high after M, or the next step's bypass cycle begins.
- A step engine sees `run` fall one cycle after asserting done. A done strobe held for more than one cycle has no further effect, because the next step's index is now current.
- Minimum run length is NUM_STEPS cycles from acceptance to DONE, with all steps bypassed or each done strobe asserted immediately.

## Configuration
- `MULTI_STEP_SEQR_TIMEOUT_EN` defined:
  - `cnt` increments every enabled STEP cycle without done.
  - If `cnt`==TIMEOUT_CYCLES-1 and the step is not done, go to ERR with `err_code`=2. Each step therefore gets exactly TIMEOUT_CYCLES run cycles.
  - Done in the final cycle wins over timeout.
- `MULTI_STEP_SEQR_TIMEOUT_EN` undefined:
  - No counter logic is built, and `err_code`=2 is never produced.
  - A step waits indefinitely.
  - The `TIMEOUT_CYCLES` parameter is unused.

## Test plan
- NUM_STEPS=4, `step_en`=4'b1111, each step's done 3 cycles after its run rises:
  - `step_run` walks 0001→0010→0100→1000.
  - `done` rises 12 cycles after acceptance.
  - `err`=0.
- `step_en`=4'b1010, done immediately:
  - Steps 0 and 2 show `step_run`=0 for exactly 1 cycle each.
  - DONE is reached 4 cycles after acceptance.
  - `step_done[0]` pulsed during the bypass is ignored.
- `abort` at the same edge as `step_done[1]`:
  - ERR with `err_code`=1 and `cur_step`=1.
  - Then `clr` gives IDLE next cycle, with `cur_step`=0 and `err_code`=0.
- With the macro defined and TIMEOUT_CYCLES=8, step 2 never done:
  - `step_run[2]` is high for exactly 8 cycles.
  - Then ERR with `err_code`=2 and `cur_step`=2.
  - A second bench with done in run cycle 8 sees an advance with no error.
- `rst` pulsed while step 1 runs:
  - All outputs go to 0 asynchronously.
  - `run` afterwards restarts at step 0.
  - `run` held high while in DONE produces no restart until `clr`.
